// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU datapath constants and round-robin grant search
package npu_pkg;

    localparam int          FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // First set bit of valid at or after ptr, wrapping at num (num <= 8).
    // Returns ptr when no bit is set; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         num);
        logic [2:0] grant;
        logic       found;
        grant = ptr;
        found = 1'b0;
        for (int i = 0; i < num; i++) begin
            if (!found && valid[3'((int'(ptr) + i) % num)]) begin
                grant = 3'((int'(ptr) + i) % num);
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/floatMult.sv
// rtl/floatMult.sv - combinational FP16 multiplier, truncating, no NaN/Inf handling
//
// Ports:
//   a, b     : FP16 operands
//   product  : FP16 product; 0x0000 for a zero operand or exponent underflow
module floatMult
    import npu_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic [FP16_W-1:0] product
);

    logic [11:0]       sig_top;
    logic signed [7:0] exp_sum;
    logic [9:0]        mant;

    always_comb begin
        // Only the upper 12 bits of the 22-bit significand product matter;
        // everything below the kept mantissa is truncated.
        sig_top = 12'(({11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]}) >> 10);
        exp_sum = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]})
                + $signed({7'd0, sig_top[11]}) - 8'sd15;
        mant    = sig_top[11] ? sig_top[10:1] : sig_top[9:0];
        product = FP16_ZERO;
        if (a != FP16_ZERO && b != FP16_ZERO && exp_sum > 8'sd0) begin
            product = {a[15] ^ b[15], exp_sum[4:0], mant};
        end
    end

endmodule

// File: rtl/fp16_mult_arbiter.sv
// rtl/fp16_mult_arbiter.sv - round-robin arbiter sharing one FP16 multiplier
//
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   req_valid / req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_a / req_b          : packed FP16 operands, requester i at [16i+15:16i]
//   rsp_valid / rsp_ready  : response handshake with backpressure
//   rsp_id, rsp_product    : requester tag and FP16 product
//   op_count               : accepted request count, wraps at 2^16
module fp16_mult_arbiter
    import npu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP16_W*NUM_REQ-1:0] req_a,
    input  logic [FP16_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [FP16_W-1:0]         rsp_product,
    output logic [15:0]               op_count
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              s1_valid;
    logic [FP16_W-1:0] s1_a;
    logic [FP16_W-1:0] s1_b;
    logic [ID_W-1:0]   s1_id;
    logic [FP16_W-1:0] mult_out;
    logic              s2_load;
    logic              s1_load;
    logic              accept;

    always_comb begin
        grant   = ID_W'(rr_pick(8'(req_valid), 3'(rr_ptr), NUM_REQ));
        s2_load = !rsp_valid || rsp_ready;
        s1_load = !s1_valid || s2_load;
        // reset gates accept so req_ready is low for the whole reset window,
        // even though the cleared pipeline would otherwise look loadable.
        accept  = (|req_valid) && s1_load && !reset;
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= FP16_ZERO;
            s1_b     <= FP16_ZERO;
            s1_id    <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a  <= req_a[grant*FP16_W +: FP16_W];
                s1_b  <= req_b[grant*FP16_W +: FP16_W];
                s1_id <= grant;
            end
        end
    end

    floatMult u_mult (
        .a       (s1_a),
        .b       (s1_b),
        .product (mult_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_product <= FP16_ZERO;
            rsp_id      <= '0;
        end else if (s2_load) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_product <= mult_out;
                rsp_id      <= s1_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            op_count <= 16'd0;
        end else if (accept) begin
            rr_ptr   <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// tb/tb_fp16_mult_arbiter.sv - scoreboard bench for fp16_mult_arbiter
module tb_fp16_mult_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_product;
    logic [15:0]       op_count;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] prod;
        int          edge_n;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          errors   = 0;
    int          edge_cnt = 0;
    int          ptr      = 0;
    logic [15:0] cnt      = 16'd0;
    bit          mon_en   = 1'b0;

    fp16_mult_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // Reference product: significands as integers, halve once if the product
    // reaches 2.0, drop fraction bits below the 10-bit mantissa.
    function automatic logic [15:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
        int sig;
        int e;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        sig = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        e   = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (sig >= (1 << 21)) begin
            sig = sig / 2;
            e   = e + 1;
        end
        if (e <= 0) return 16'h0000;
        return {a[15] ^ b[15], 5'(e), 10'(sig / 1024 - 1024)};
    endfunction

    function automatic logic [15:0] rand_op();
        if ($urandom_range(15) == 0) return 16'h0000;
        return {1'($urandom_range(1)), 5'($urandom_range(22, 1)), 10'($urandom_range(1023))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
    endtask

    task automatic step(input logic [N-1:0] v, input logic rr, input bit fixed,
                        input logic [15:0] fa, input logic [15:0] fb);
        int           g;
        bit           can_load;
        logic [N-1:0] exp_ready;
        logic [15:0]  ga;
        logic [15:0]  gb;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = fixed ? fa : rand_op();
            req_b[16*i +: 16] = fixed ? fb : rand_op();
        end
        #1;
        // The pipeline holds at most two products; a full pipeline accepts
        // only when the head is draining this cycle.
        can_load = (sbq.size() < 2) || rr;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
        end
        exp_ready = '0;
        ga = 16'h0000;
        gb = 16'h0000;
        if (g >= 0 && can_load) begin
            exp_ready[g] = 1'b1;
            ga = req_a[16*g +: 16];
            gb = req_b[16*g +: 16];
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("op_count", 32'(op_count), 32'(cnt));
        tick();
        if (g >= 0 && can_load) begin
            sbq.push_back('{id: 2'(g), prod: ref_mult(ga, gb), edge_n: edge_cnt});
            ptr = (g + 1) % N;
            cnt++;
        end
    endtask

    task automatic step_fixed(input logic [N-1:0] v, input logic [15:0] fa, input logic [15:0] fb);
        step(v, 1'b1, 1'b1, fa, fb);
    endtask

    task automatic step_rand(input logic [N-1:0] v, input logic rr);
        step(v, rr, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Monitor: a product is expected once it was accepted at an earlier edge
    // and everything accepted before it has drained.
    initial begin
        forever begin
            bit ev;
            @(negedge clk);
            #2;
            if (mon_en) begin
                ev = (sbq.size() > 0) && (sbq[0].edge_n < edge_cnt);
                check("rsp_valid", 32'(rsp_valid), 32'(ev));
                if (ev && rsp_valid) begin
                    check("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
                    check("rsp_product", 32'(rsp_product), 32'(sbq[0].prod));
                    if (rsp_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1 reset  = 1'b1;
        @(negedge clk);
        req_valid = '1;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_op_count", 32'(op_count), 32'd0);
        check("reset_rsp_product", 32'(rsp_product), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        mon_en    = 1'b1;
        tick();

        step_fixed(4'b0001, 16'h3C00, 16'h4000);
        repeat (2) step_rand(4'b0000, 1'b1);

        repeat (8) step_fixed(4'b1111, 16'h4000, 16'h4200);
        repeat (2) step_rand(4'b0000, 1'b1);

        step_fixed(4'b0001, 16'hBC00, 16'h3C00);
        step_fixed(4'b0001, 16'h0000, 16'h5555);
        repeat (2) step_rand(4'b0000, 1'b1);

        repeat (5) step_rand(4'b0110, 1'b0);
        repeat (3) step_rand(4'b0000, 1'b1);

        repeat (2) step_rand(4'b0011, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '1;
        sbq.delete();
        ptr = 0;
        cnt = 16'd0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_op_count", 32'(op_count), 32'd0);
        check("midreset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("midreset_req_ready", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        tick();
        step_rand(4'b1111, 1'b1);
        repeat (3) step_rand(4'b0000, 1'b1);

        repeat (300) step_rand(4'($urandom), 1'($urandom_range(3) != 0));
        repeat (3) step_rand(4'b0000, 1'b1);

        repeat (65536 + 4) step_rand(4'b0001, 1'b1);
        repeat (3) step_rand(4'b0000, 1'b1);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
